dram_arb: RTL
=============

DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 The module SHALL provide the following parameters, one per line: name, default, meaning.
- RD_LAT, 1, DRAM read latency in cycles, from dram_ren sampled to dram_rdata valid; legal range 1-4.
- STARVE_MAX, 4, consecutive write grants allowed while a read is pending.
REQ-002 The module SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic is on the rising edge.
- rst, in, 1, reset; synchronous, active-high.
- rd0_req, in, 1, read client 0 request.
- rd0_addr, in, 19, read client 0 address.
- rd0_gnt, out, 1, read client 0 accepted this cycle.
- rd0_vld, out, 1, read client 0 data valid.
- rd1_req, in, 1, read client 1 request.
- rd1_addr, in, 19, read client 1 address.
- rd1_gnt, out, 1, read client 1 accepted this cycle.
- rd1_vld, out, 1, read client 1 data valid.
- rd_data, out, 392, returned 49-byte window, shared by both read clients.
- wr_req, in, 1, write client request.
- wr_addr, in, 19, write address.
- wr_data, in, 8, write byte.
- wr_gnt, out, 1, write accepted this cycle.
- dram_ren, out, 1, DRAM read enable.
- dram_wen, out, 1, DRAM write enable.
- dram_raddr, out, 19, DRAM read address.
- dram_waddr, out, 19, DRAM write address.
- dram_wdata, out, 8, DRAM write byte.
- dram_rdata, in, 392, DRAM read data.

Function
REQ-003 Grants SHALL be combinational from the requests and the registered arbiter state; a transfer is accepted when req and gnt are both high in the same cycle.
REQ-004 At most one of rd0_gnt, rd1_gnt and wr_gnt SHALL be high in any cycle.
REQ-005 Priority SHALL be: write first, then reads in round-robin order; rr_last records the last read client granted and resets to 1, so client 0 wins first.
REQ-006 On an accept in cycle N, the module SHALL register dram_ren/dram_raddr or dram_wen/dram_waddr/dram_wdata so they are valid in cycle N+1 for exactly one cycle; otherwise all DRAM enables SHALL be 0.
REQ-007 For a read accepted in cycle N, the module SHALL assert rdX_vld in cycle N+1+RD_LAT for one cycle, with rd_data = dram_rdata in that cycle.
REQ-008 Read ownership SHALL be tracked by a tag shift register of depth RD_LAT+1 so that back-to-back reads from alternating clients return in order.
REQ-009 dram_raddr and dram_waddr SHALL hold their last values when not enabled; rd_data SHALL hold its last value when no rdX_vld is asserted.
REQ-010 The module SHALL contain a two-state FSM: WPRI, where writes win, and RFORCE, where a pending read wins over a write.
- WPRI -> RFORCE when the starve counter reaches STARVE_MAX.
- RFORCE -> WPRI after one read grant.
REQ-011 The starve counter SHALL increment on each write grant while rd0_req or rd1_req is high, clear on any read grant, clear when no read is pending, and saturate at STARVE_MAX.
REQ-012 Reads and writes SHALL be accepted every cycle with no bubble, up to one transfer per cycle in total.
REQ-013 The arbiter SHALL perform no address hazard check; the write client owns ordering.

Reset
REQ-014 While rst is high, the module SHALL force:
- all gnt, vld and dram enables to 0;
- dram addresses and wdata to 0, and rd_data to 0;
- the tag pipeline to empty;
- the FSM to WPRI, the starve counter to 0, and rr_last to 1.
REQ-015 A reset asserted with reads in flight SHALL discard them, with no vld pulse after reset even if dram_rdata changes.

Configuration
REQ-016 The macro DRAM_ARB_STARVE_EN SHALL control starvation protection.
- Defined: the RFORCE state and the starve counter are present as in REQ-010 and REQ-011.
- Undefined: the FSM stays in WPRI permanently, so writes have strict priority and reads may starve.

Verification
REQ-017 A bench SHALL cover the following directed scenarios, one line each: stimulus -> required response.
- Reset: rst high for 2 cycles with all requests high -> all outputs 0; then rd0_req, rd1_req and wr_req all high -> the first cycle grants wr.
- Single read: rd0_req with addr 19'd3 in cycle N, RD_LAT=1 -> dram_ren=1, raddr=3 in N+1; rd0_vld=1 with rd_data=dram_rdata in N+2.
- Round-robin: rd0 and rd1 both request continuously -> grants alternate 0,1,0,1, and vld pulses follow the same order with 2-cycle latency.
- Starvation, macro defined: wr_req and rd1_req held high -> 4 write grants, 1 read grant, repeating; undefined -> rd1_gnt never asserts.
- Write path: wr_req with addr 19'd5, data 8'hA5 -> dram_wen=1, waddr=5, wdata=A5 for one cycle in N+1.
- Mid-operation reset: rst in the cycle after a read grant -> no rd0_vld or rd1_vld pulse afterwards.

Source files
------------

// File: rtl/dram_arb.sv
// dram_arb: one-transfer-per-cycle arbiter for two read clients and one
// write client sharing a single DRAM port with fixed read latency.
// Ports: clk, rst (sync, active-high); rd0_*/rd1_* read req/addr/gnt/vld;
//   rd_data shared 392-bit return; wr_req/addr/data/gnt write client;
//   dram_ren/wen/raddr/waddr/wdata to DRAM, dram_rdata from DRAM.
// Macro DRAM_ARB_STARVE_EN enables forced read service after STARVE_MAX
// consecutive write grants while a read waits.
module dram_arb #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd0_req,
    input  logic [18:0]  rd0_addr,
    output logic         rd0_gnt,
    output logic         rd0_vld,
    input  logic         rd1_req,
    input  logic [18:0]  rd1_addr,
    output logic         rd1_gnt,
    output logic         rd1_vld,
    output logic [391:0] rd_data,
    input  logic         wr_req,
    input  logic [18:0]  wr_addr,
    input  logic [7:0]   wr_data,
    output logic         wr_gnt,
    output logic         dram_ren,
    output logic         dram_wen,
    output logic [18:0]  dram_raddr,
    output logic [18:0]  dram_waddr,
    output logic [7:0]   dram_wdata,
    input  logic [391:0] dram_rdata
);

    typedef enum logic {WPRI, RFORCE} state_t;

    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           rr_last;
    logic [RD_LAT:0] tv;
    logic [RD_LAT:0] tc;
    logic           ren_q;
    logic           wen_q;
    logic [18:0]    raddr_q;
    logic [18:0]    waddr_q;
    logic [7:0]     wdata_q;
    logic [391:0]   rdata_q;

    logic rd_any;
    logic force_rd;
    logic rd0_win;
    logic g_w;
    logic g_r0;
    logic g_r1;
    logic g_rd;

    assign rd_any   = rd0_req | rd1_req;
    assign force_rd = (state == RFORCE) && rd_any;
    // rr_last==1 means client 1 went last, so client 0 is next
    assign rd0_win  = rd0_req && (!rd1_req || rr_last);
    assign g_w      = !rst && wr_req && !force_rd;
    assign g_r0     = !rst && !g_w && rd0_win;
    assign g_r1     = !rst && !g_w && rd1_req && !rd0_win;
    assign g_rd     = g_r0 | g_r1;

    assign rd0_gnt = g_r0;
    assign rd1_gnt = g_r1;
    assign wr_gnt  = g_w;

    // Write streak seen by a waiting read; kept in both builds, but only
    // the forcing FSM below acts on it.
    always_comb begin
        cnt_nxt = cnt;
        if (g_rd || !rd_any) begin
            cnt_nxt = '0;
        end else if (g_w && cnt != CW'(STARVE_MAX)) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WPRI;
            cnt   <= '0;
        end else begin
            cnt <= cnt_nxt;
`ifdef DRAM_ARB_STARVE_EN
            unique case (state)
                WPRI: begin
                    if (cnt_nxt == CW'(STARVE_MAX)) state <= RFORCE;
                end
                RFORCE: begin
                    if (g_rd) state <= WPRI;
                end
                default: state <= WPRI;
            endcase
`else
            state <= WPRI;
`endif
        end
    end

    // tv/tc: in-flight read valid and owner, one stage per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            tv      <= '0;
            tc      <= '0;
            rdata_q <= '0;
        end else begin
            ren_q <= g_rd;
            wen_q <= g_w;
            if (g_rd) begin
                raddr_q <= g_r0 ? rd0_addr : rd1_addr;
                rr_last <= g_r1;
            end
            if (g_w) begin
                waddr_q <= wr_addr;
                wdata_q <= wr_data;
            end
            tv <= {tv[RD_LAT-1:0], g_rd};
            tc <= {tc[RD_LAT-1:0], g_r1};
            if (tv[RD_LAT]) rdata_q <= dram_rdata;
        end
    end

    assign rd0_vld    = !rst && tv[RD_LAT] && !tc[RD_LAT];
    assign rd1_vld    = !rst && tv[RD_LAT] && tc[RD_LAT];
    assign rd_data    = rst ? '0 : (tv[RD_LAT] ? dram_rdata : rdata_q);
    assign dram_ren   = !rst && ren_q;
    assign dram_wen   = !rst && wen_q;
    assign dram_raddr = rst ? '0 : raddr_q;
    assign dram_waddr = rst ? '0 : waddr_q;
    assign dram_wdata = rst ? '0 : wdata_q;

endmodule
